// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_port_arbiter_pkg : shared widths, source ids and helpers for the       |
// | register-file write-back arbiter.                  Revision: 1.0          |
// +--------------------------------------------------------------------------+
package wb_port_arbiter_pkg;

    localparam int REG_AW  = 5;
    localparam int REG_DW  = 32;
    localparam int WB_NREQ = 3;

    typedef enum logic [1:0] {
        WB_SRC_ALU = 2'd0,
        WB_SRC_MEM = 2'd1,
        WB_SRC_MDU = 2'd2
    } wb_src_e;

    function automatic int wb_wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_port_arbiter_if : requester handshake, register-file write port and    |
// | decode status bundle.                              Revision: 1.0          |
// +--------------------------------------------------------------------------+
interface wb_port_arbiter_if
    import wb_port_arbiter_pkg::*;
#(
    parameter int NREQ = WB_NREQ,
    parameter int AW   = REG_AW,
    parameter int DW   = REG_DW
) ();

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_pos;
    logic [NREQ*DW-1:0] req_data;
    logic               wb_en;
    logic [AW-1:0]      wb_pos;
    logic [DW-1:0]      wb_data;
    logic [2**AW-1:0]   pending_mask;
    logic               idle;

    modport master (
        output req_valid, req_pos, req_data,
        input  req_ready, wb_en, wb_pos, wb_data, pending_mask, idle
    );

    modport slave (
        input  req_valid, req_pos, req_data,
        output req_ready, wb_en, wb_pos, wb_data, pending_mask, idle
    );

endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_pick : NREQ-wide one-hot picker. Fixed priority (lowest index) by      |
// | default; round-robin from i_ptr when WB_ARB_RR_EN is defined. Rev: 1.0    |
// +--------------------------------------------------------------------------+
module wb_pick #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]         i_req,
`ifdef WB_ARB_RR_EN
    input  logic [$clog2(NREQ)-1:0] i_ptr,
`endif
    output logic [NREQ-1:0]         o_gnt,
    output logic [$clog2(NREQ)-1:0] o_gnt_idx
);

    localparam int c_pw = $clog2(NREQ);

`ifdef WB_ARB_RR_EN
    logic [NREQ-1:0] w_rot;
    logic [c_pw:0]   w_sum;
    logic            w_found;

    // Rotate so the search starts at i_ptr, then map the winning offset back.
    always_comb begin
        w_rot   = NREQ'({i_req, i_req} >> i_ptr);
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, i_ptr} + (c_pw+1)'(k);
            end
        end
        if (w_sum >= (c_pw+1)'(NREQ)) begin
            w_sum = w_sum - (c_pw+1)'(NREQ);
        end
        o_gnt_idx = w_sum[c_pw-1:0];
        o_gnt     = w_found ? (NREQ'(1) << o_gnt_idx) : '0;
    end
`else
    logic w_found;

    always_comb begin
        w_found   = 1'b0;
        o_gnt     = '0;
        o_gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && i_req[k]) begin
                w_found   = 1'b1;
                o_gnt[k]  = 1'b1;
                o_gnt_idx = c_pw'(k);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_port_arbiter : shares the register-file write port among NREQ sources  |
// | with WAW ordering. WB_ARB_RR_EN selects round-robin.   Revision: 1.0      |
// +--------------------------------------------------------------------------+
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int NREQ = WB_NREQ,
    parameter int AW   = REG_AW,
    parameter int DW   = REG_DW
) (
    input  logic             clk,
    input  logic             resetn,
    wb_port_arbiter_if.slave bus
);

    localparam int c_pw = $clog2(NREQ);

    logic [NREQ-1:0]  r_full;
    logic [AW-1:0]    r_pos  [NREQ];
    logic [DW-1:0]    r_data [NREQ];
    logic             r_wb_en;
    logic [AW-1:0]    r_wb_pos;
    logic [DW-1:0]    r_wb_data;

    logic [AW-1:0]    w_req_pos  [NREQ];
    logic [DW-1:0]    w_req_data [NREQ];
    logic [NREQ-1:0]  w_gnt;
    logic [NREQ-1:0]  w_waw;
    logic [NREQ-1:0]  w_ready;
    logic [NREQ-1:0]  w_acc;
    logic [c_pw-1:0]  w_gnt_idx;
    logic [AW-1:0]    w_gnt_pos;
    logic [DW-1:0]    w_gnt_data;
    logic [2**AW-1:0] w_mask;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_req_pos[gi]  = bus.req_pos[gi*AW +: AW];
        assign w_req_data[gi] = bus.req_data[gi*DW +: DW];
    end

`ifdef WB_ARB_RR_EN
    logic [c_pw-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ptr <= '0;
        end else if (|w_gnt) begin
            r_ptr <= c_pw'(wb_wrap_inc(int'(w_gnt_idx), NREQ));
        end
    end
`endif

    wb_pick #(
        .NREQ      (NREQ)
    ) u_pick (
        .i_req     (r_full),
`ifdef WB_ARB_RR_EN
        .i_ptr     (r_ptr),
`endif
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    assign w_gnt_pos  = r_pos[w_gnt_idx];
    assign w_gnt_data = r_data[w_gnt_idx];

    // A write may not overtake an older same-register write still waiting in
    // another slot, nor a lower-index requester targeting the same register.
    always_comb begin
        w_waw = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_req_pos[i] != '0) begin
                for (int j = 0; j < NREQ; j++) begin
                    if (j != i && r_full[j] && !w_gnt[j] && r_pos[j] == w_req_pos[i]) begin
                        w_waw[i] = 1'b1;
                    end
                    if (j < i && bus.req_valid[j] && w_req_pos[j] == w_req_pos[i]) begin
                        w_waw[i] = 1'b1;
                    end
                end
            end
        end
    end

    assign w_ready = {NREQ{resetn}} & (~r_full | w_gnt) & ~w_waw;
    assign w_acc   = bus.req_valid & w_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_full    <= '0;
            r_wb_en   <= 1'b0;
            r_wb_pos  <= '0;
            r_wb_data <= '0;
            for (int k = 0; k < NREQ; k++) begin
                r_pos[k]  <= '0;
                r_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (w_acc[k]) begin
                    r_full[k] <= 1'b1;
                    r_pos[k]  <= w_req_pos[k];
                    r_data[k] <= w_req_data[k];
                end else if (w_gnt[k]) begin
                    r_full[k] <= 1'b0;
                end
            end
            // r0 writes drain through the port but never assert the enable.
            if (|w_gnt) begin
                r_wb_en   <= (w_gnt_pos != '0);
                r_wb_pos  <= w_gnt_pos;
                r_wb_data <= w_gnt_data;
            end else begin
                r_wb_en   <= 1'b0;
            end
        end
    end

    always_comb begin
        w_mask = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (r_full[k]) begin
                w_mask[r_pos[k]] = 1'b1;
            end
        end
        if (r_wb_en) begin
            w_mask[r_wb_pos] = 1'b1;
        end
        w_mask[0] = 1'b0;
        if (!resetn) begin
            w_mask = '0;
        end
    end

    assign bus.req_ready    = w_ready;
    assign bus.wb_en        = r_wb_en;
    assign bus.wb_pos       = r_wb_pos;
    assign bus.wb_data      = r_wb_data;
    assign bus.pending_mask = w_mask;
    assign bus.idle         = !resetn | (~|r_full & !r_wb_en);

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_port_arbiter : directed vector table plus hand sequences for the    |
// | write-back arbiter (fixed or WB_ARB_RR_EN build).  Revision: 1.0          |
// +--------------------------------------------------------------------------+
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic clk = 1'b0;
    logic resetn;
    int   n_checks = 0;
    int   n_fail   = 0;

    wb_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    wb_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]         v;
        logic [3*AW-1:0]    p;
        logic [3*DW-1:0]    d;
        logic [2:0]         e_rdy;
        logic               e_en;
        logic [AW-1:0]      e_pos;
        logic [DW-1:0]      e_data;
        logic [2**AW-1:0]   e_mask;
        logic               e_idle;
    } vec_t;

    vec_t tbl[$];

    task automatic add_row(input logic [2:0] v, input logic [3*AW-1:0] p,
                           input logic [3*DW-1:0] d, input logic [2:0] rdy,
                           input logic en, input logic [AW-1:0] wpos,
                           input logic [DW-1:0] wdata, input logic [2**AW-1:0] mask,
                           input logic idl);
        vec_t r;
        r = '{v, p, d, rdy, en, wpos, wdata, mask, idl};
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [3*AW-1:0] p, input logic [3*DW-1:0] d);
        bus.req_valid = v;
        bus.req_pos   = p;
        bus.req_data  = d;
    endtask

    // Drive just after the active edge, observe on the falling edge.
    task automatic cyc(input logic [2:0] v, input logic [3*AW-1:0] p, input logic [3*DW-1:0] d);
        @(posedge clk);
        #1;
        drive(v, p, d);
        @(negedge clk);
    endtask

    localparam logic [3*AW-1:0] P123 = {5'd3, 5'd2, 5'd1};
    localparam logic [3*DW-1:0] D123 = {32'h33, 32'h22, 32'h11};
    localparam logic [DW-1:0]   DBEF = 32'hDEADBEEF;
`ifdef WB_ARB_RR_EN
    localparam logic [AW-1:0]   HOLD_POS  = 5'd1;
    localparam logic [DW-1:0]   HOLD_DATA = 32'h11;
`else
    localparam logic [AW-1:0]   HOLD_POS  = 5'd3;
    localparam logic [DW-1:0]   HOLD_DATA = 32'h33;
`endif

    initial begin
        // single write to r5
        add_row(3'b001, 15'd5, {64'h0, DBEF}, 3'b111, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
        add_row(3'b000, 15'd0, 96'h0,         3'b111, 1'b0, 5'd0, 32'h0, 32'h20, 1'b0);
        add_row(3'b000, 15'd0, 96'h0,         3'b111, 1'b1, 5'd5, DBEF,  32'h20, 1'b0);
        add_row(3'b000, 15'd0, 96'h0,         3'b111, 1'b0, 5'd5, DBEF,  32'h0,  1'b1);
        // three-way contention
        add_row(3'b111, P123,  D123,          3'b111, 1'b0, 5'd5, DBEF,  32'h0,  1'b1);
`ifdef WB_ARB_RR_EN
        add_row(3'b000, 15'd0, 96'h0, 3'b010, 1'b0, 5'd5, DBEF,   32'h0E, 1'b0);
        add_row(3'b000, 15'd0, 96'h0, 3'b110, 1'b1, 5'd2, 32'h22, 32'h0E, 1'b0);
        add_row(3'b000, 15'd0, 96'h0, 3'b111, 1'b1, 5'd3, 32'h33, 32'h0A, 1'b0);
        add_row(3'b000, 15'd0, 96'h0, 3'b111, 1'b1, 5'd1, 32'h11, 32'h02, 1'b0);
`else
        add_row(3'b000, 15'd0, 96'h0, 3'b001, 1'b0, 5'd5, DBEF,   32'h0E, 1'b0);
        add_row(3'b000, 15'd0, 96'h0, 3'b011, 1'b1, 5'd1, 32'h11, 32'h0E, 1'b0);
        add_row(3'b000, 15'd0, 96'h0, 3'b111, 1'b1, 5'd2, 32'h22, 32'h0C, 1'b0);
        add_row(3'b000, 15'd0, 96'h0, 3'b111, 1'b1, 5'd3, 32'h33, 32'h08, 1'b0);
`endif
        add_row(3'b000, 15'd0, 96'h0, 3'b111, 1'b0, HOLD_POS, HOLD_DATA, 32'h0, 1'b1);
        // r0 write drains without enabling the port
        add_row(3'b001, 15'd0, {64'h0, 32'h1234}, 3'b111, 1'b0, HOLD_POS, HOLD_DATA, 32'h0, 1'b1);
        add_row(3'b000, 15'd0, 96'h0, 3'b111, 1'b0, HOLD_POS, HOLD_DATA, 32'h0, 1'b0);
        add_row(3'b000, 15'd0, 96'h0, 3'b111, 1'b0, 5'd0, 32'h1234, 32'h0, 1'b1);

        // reset held with all requesters valid
        resetn = 1'b0;
        drive(3'b111, P123, D123);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst%0d.ready", c), 64'(bus.req_ready), 64'h0);
            chk($sformatf("rst%0d.wb_en", c), 64'(bus.wb_en), 64'h0);
            chk($sformatf("rst%0d.mask", c), 64'(bus.pending_mask), 64'h0);
            chk($sformatf("rst%0d.idle", c), 64'(bus.idle), 64'h1);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        drive(3'b000, 15'd0, 96'h0);
        @(negedge clk);
        chk("rel.ready", 64'(bus.req_ready), 64'h7);
        chk("rel.idle", 64'(bus.idle), 64'h1);
        chk("rel.mask", 64'(bus.pending_mask), 64'h0);

        foreach (tbl[n]) begin
            cyc(tbl[n].v, tbl[n].p, tbl[n].d);
            chk($sformatf("row%0d.ready", n), 64'(bus.req_ready), 64'(tbl[n].e_rdy));
            chk($sformatf("row%0d.wb_en", n), 64'(bus.wb_en), 64'(tbl[n].e_en));
            chk($sformatf("row%0d.wb_pos", n), 64'(bus.wb_pos), 64'(tbl[n].e_pos));
            chk($sformatf("row%0d.wb_data", n), 64'(bus.wb_data), 64'(tbl[n].e_data));
            chk($sformatf("row%0d.mask", n), 64'(bus.pending_mask), 64'(tbl[n].e_mask));
            chk($sformatf("row%0d.idle", n), 64'(bus.idle), 64'(tbl[n].e_idle));
        end

        // WAW: MEM and MDU both target r7; MEM must reach the port first
        cyc(3'b110, {5'd7, 5'd7, 5'd0}, {32'h77B, 32'h77A, 32'h0});
        chk("waw1.ready", 64'(bus.req_ready), 64'h3);
        cyc(3'b100, {5'd7, 5'd0, 5'd0}, {32'h77B, 32'h0, 32'h0});
        chk("waw2.ready", 64'(bus.req_ready), 64'h7);
        chk("waw2.wb_en", 64'(bus.wb_en), 64'h0);
        cyc(3'b000, 15'd0, 96'h0);
        chk("waw3.wb_en", 64'(bus.wb_en), 64'h1);
        chk("waw3.wb_pos", 64'(bus.wb_pos), 64'h7);
        chk("waw3.wb_data", 64'(bus.wb_data), 64'h77A);
        chk("waw3.mask", 64'(bus.pending_mask), 64'h80);
        cyc(3'b000, 15'd0, 96'h0);
        chk("waw4.wb_en", 64'(bus.wb_en), 64'h1);
        chk("waw4.wb_data", 64'(bus.wb_data), 64'h77B);
        chk("waw4.mask", 64'(bus.pending_mask), 64'h80);
        cyc(3'b000, 15'd0, 96'h0);
        chk("waw5.wb_en", 64'(bus.wb_en), 64'h0);
        chk("waw5.idle", 64'(bus.idle), 64'h1);

        // reset while all three slots are full
        cyc(3'b111, P123, {32'hC, 32'hB, 32'hA});
        chk("mid1.ready", 64'(bus.req_ready), 64'h7);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        drive(3'b000, 15'd0, 96'h0);
        @(negedge clk);
        chk("mid2.ready", 64'(bus.req_ready), 64'h0);
        chk("mid2.mask", 64'(bus.pending_mask), 64'h0);
        chk("mid2.idle", 64'(bus.idle), 64'h1);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("mid%0d.wb_en", c + 3), 64'(bus.wb_en), 64'h0);
            chk($sformatf("mid%0d.idle", c + 3), 64'(bus.idle), 64'h1);
            chk($sformatf("mid%0d.mask", c + 3), 64'(bus.pending_mask), 64'h0);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
